uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, SHALL set the clock cycles per serial bit; legal values are even numbers from 4 to 16.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the data bits per frame; legal range is 5 to 8.
REQ-003 Port clk, input, 1 bit, SHALL be the single system clock; all logic is rising-edge triggered.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-005 Port serial_in, input, 1 bit, SHALL be the asynchronous serial line; it idles high.
REQ-006 Port data_read, input, 1 bit, SHALL be a consumer acknowledge that clears data_ready and overrun_error.
REQ-007 Port rx_data, output, DATA_BITS wide, SHALL hold the last good received byte, LSB-aligned.
REQ-008 Port data_ready, output, 1 bit, SHALL indicate that rx_data is valid and unread.
REQ-009 Port overrun_error, output, 1 bit, SHALL indicate that a new byte overwrote an unread byte.
REQ-010 Port framing_error, output, 1 bit, SHALL indicate that the last frame had a low stop bit.
REQ-011 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
REQ-012 serial_in SHALL pass through a 2-flop synchronizer; a falling edge SHALL be detected only when the synchronized value is 0 and its previous value was 1.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and LOAD.
REQ-014 IDLE SHALL go to START on a detected falling edge; any other condition SHALL hold IDLE.
REQ-015 Entering START SHALL clear framing_error.
REQ-016 START SHALL sample the synchronized line CLKS_PER_BIT/2 cycles after entry.
REQ-017 In START, a sample of 1 SHALL be a false start and return the FSM to IDLE with no flag change; a sample of 0 SHALL go to DATA.
REQ-018 DATA SHALL sample every CLKS_PER_BIT cycles.
REQ-019 DATA SHALL shift samples into a DATA_BITS-wide register LSB-first.
REQ-020 DATA SHALL go to STOP after the DATA_BITS-th sample.
REQ-021 STOP SHALL sample once, CLKS_PER_BIT cycles after the last data sample.
REQ-022 In STOP, a sample of 1 SHALL go to LOAD.
REQ-023 In STOP, a sample of 0 SHALL set framing_error, leave rx_data and data_ready unchanged, and return the FSM to IDLE.
REQ-024 LOAD SHALL last exactly 1 cycle.
REQ-025 LOAD SHALL copy the shift register to rx_data and set data_ready.
REQ-026 LOAD SHALL set overrun_error if data_ready was already 1 and data_read is 0 in that cycle; the FSM SHALL then return to IDLE.
REQ-027 data_read SHALL clear data_ready and overrun_error on the next edge, except when LOAD occurs in the same cycle.
REQ-028 When data_read coincides with LOAD, LOAD SHALL win: data_ready = 1 and overrun_error = 0.
REQ-029 data_ready SHALL rise exactly 3 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the first posedge that captures serial_in = 0; this is 98 cycles for the defaults.
REQ-030 A falling edge during START, DATA or STOP SHALL be ignored, with no resynchronization.
REQ-031 The sample counter and bit counter SHALL clear on every state entry, so no count wraps across frames.

Reset
REQ-032 Asserting rst at any clock edge SHALL force IDLE, abort any frame in progress, and clear all counters and the shift register.
REQ-033 During reset, rx_data, data_ready, overrun_error, framing_error and busy SHALL all be 0.
REQ-034 Both synchronizer flops SHALL reset to 1, so that reset release with the line high produces no false edge.

Structure
REQ-035 The state enum (rx_state_t) and the defaults for CLKS_PER_BIT and DATA_BITS SHALL live in the shared package uart_rx_pkg.
REQ-036 The synchronizer and edge detector SHALL be the single sub-module rx_edge_sync (ports clk, rst, async_in, sync_out, fall_edge).
REQ-037 The sample counter and bit counter SHALL be implemented inline in uart_rx_ctrl.

Verification
REQ-038 Byte 0xA5 with stop = 1 at default parameters -> rx_data = 0xA5, data_ready = 1 exactly 98 cycles after the start-bit capture, and all error flags 0.
REQ-039 A low glitch of 3 cycles on an idle line -> FSM back in IDLE after the START sample, busy low, data_ready 0, and no flags set.
REQ-040 Byte 0x3C with stop bit = 0 -> framing_error = 1, data_ready 0, rx_data unchanged; framing_error clears at the next start bit.
REQ-041 Two bytes 0x11 then 0x22 with no data_read -> rx_data = 0x22, data_ready = 1, overrun_error = 1; a 1-cycle data_read then clears both flags.
REQ-042 data_read asserted in the LOAD cycle of byte 0x7E while data_ready = 1 -> data_ready stays 1 and overrun_error = 0.
REQ-043 rst asserted in the middle of the DATA state -> all outputs 0 on the next edge; a following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and default parameters for the UART receive controller.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_edge_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
module rx_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All flops reset high so an idle line after reset yields no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync_out  = r_sync;
  assign fall_edge = ~r_sync & r_prev;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start/data/stop framing with
// data_ready, overrun and framing-error status.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_next;

  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_ready;
  logic                 r_ovr;
  logic                 r_fe;

  logic w_sync;
  logic w_fall;
  logic w_start_smp;
  logic w_data_smp;
  logic w_stop_smp;

  rx_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (serial_in),
    .sync_out  (w_sync),
    .fall_edge (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_smp  = 1'b0;
    w_data_smp   = 1'b0;
    w_stop_smp   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) w_state_next = START;
      end
      START: begin
        w_start_smp = (r_cnt == HALF_LAST);
        if (w_start_smp)
          w_state_next = w_sync ? IDLE : DATA;
      end
      DATA: begin
        w_data_smp = (r_cnt == FULL_LAST);
        if (w_data_smp && r_bit == BIT_LAST)
          w_state_next = STOP;
      end
      STOP: begin
        w_stop_smp = (r_cnt == FULL_LAST);
        if (w_stop_smp)
          w_state_next = w_sync ? LOAD : IDLE;
      end
      LOAD: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Counters restart on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (w_data_smp) begin
      r_cnt <= '0;
      r_bit <= r_bit + 1'b1;
    end else if (r_state == START || r_state == DATA
                 || r_state == STOP) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_rx_data <= '0;
      r_ready   <= 1'b0;
      r_ovr     <= 1'b0;
      r_fe      <= 1'b0;
    end else begin
      if (w_data_smp)
        r_shift <= {w_sync, r_shift[DATA_BITS-1:1]};
      if (r_state == IDLE && w_fall)
        r_fe <= 1'b0;
      else if (w_stop_smp && !w_sync)
        r_fe <= 1'b1;
      // A load in the same cycle as data_read takes priority
      if (r_state == LOAD) begin
        r_rx_data <= r_shift;
        r_ready   <= 1'b1;
        r_ovr     <= r_ready & ~data_read;
      end else if (data_read) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign data_ready    = r_ready;
  assign overrun_error = r_ovr;
  assign framing_error = r_fe;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at default parameters.
module tb_uart_rx_ctrl;

  localparam int CPB = 10;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          data_read;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int rdy_k;
  logic fe_mid;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge; reports the first negedge
  // index at which data_ready is seen high and framing_error at k=5.
  task automatic send(input logic [7:0] b, input logic stopb,
                      input int read_k, output int rk,
                      output logic fem);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    rk = -1;
    fem = 1'b0;
    serial_in = fr[0];
    data_read = (read_k == 0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rk < 0 && data_ready) rk = k;
      if (k == 5) fem = framing_error;
      serial_in = (k < 100) ? fr[k / 10] : 1'b1;
      data_read = (k == read_k);
    end
    data_read = 1'b0;
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    data_read = 1'b0;
    idle(3);
    chk("rst_data",  rx_data, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_ovr",   overrun_error, 0);
    chk("rst_fe",    framing_error, 0);
    chk("rst_busy",  busy, 0);
    rst = 1'b0;
    idle(5);

    send(8'hA5, 1'b1, -1, rdy_k, fe_mid);
    chk("a5_latency", rdy_k, 99);
    chk("a5_data",  rx_data, 8'hA5);
    chk("a5_ready", data_ready, 1);
    chk("a5_ovr",   overrun_error, 0);
    chk("a5_fe",    framing_error, 0);
    pulse_read();
    chk("a5_read_clr", data_ready, 0);

    serial_in = 1'b0;
    idle(3);
    chk("gl_busy_mid", busy, 1);
    serial_in = 1'b1;
    idle(12);
    chk("gl_busy",  busy, 0);
    chk("gl_ready", data_ready, 0);
    chk("gl_fe",    framing_error, 0);
    chk("gl_ovr",   overrun_error, 0);

    send(8'h3C, 1'b0, -1, rdy_k, fe_mid);
    chk("fe_set",   framing_error, 1);
    chk("fe_ready", data_ready, 0);
    chk("fe_data",  rx_data, 8'hA5);
    chk("fe_busy",  busy, 0);
    idle(5);

    send(8'h11, 1'b1, -1, rdy_k, fe_mid);
    chk("fe_clr_start", fe_mid, 0);
    chk("b11_data",  rx_data, 8'h11);
    chk("b11_ovr",   overrun_error, 0);
    idle(5);
    send(8'h22, 1'b1, -1, rdy_k, fe_mid);
    chk("ov_data",  rx_data, 8'h22);
    chk("ov_ready", data_ready, 1);
    chk("ov_ovr",   overrun_error, 1);
    pulse_read();
    chk("ov_clr_ready", data_ready, 0);
    chk("ov_clr_ovr",   overrun_error, 0);

    send(8'h55, 1'b1, -1, rdy_k, fe_mid);
    chk("b55_ready", data_ready, 1);
    idle(5);
    send(8'h7E, 1'b1, 98, rdy_k, fe_mid);
    chk("lw_data",  rx_data, 8'h7E);
    chk("lw_ready", data_ready, 1);
    chk("lw_ovr",   overrun_error, 0);
    idle(5);

    serial_in = 1'b0;
    idle(10);
    serial_in = 1'b1;
    idle(30);
    chk("ab_busy", busy, 1);
    rst = 1'b1;
    idle(1);
    chk("ab_data",  rx_data, 0);
    chk("ab_ready", data_ready, 0);
    chk("ab_ovr",   overrun_error, 0);
    chk("ab_fe",    framing_error, 0);
    chk("ab_busy0", busy, 0);
    rst = 1'b0;
    idle(20);
    send(8'hC3, 1'b1, -1, rdy_k, fe_mid);
    chk("c3_latency", rdy_k, 99);
    chk("c3_data",  rx_data, 8'hC3);
    chk("c3_ready", data_ready, 1);
    chk("c3_fe",    framing_error, 0);
    chk("c3_ovr",   overrun_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
